// File: rtl/rv32i_regfile_ctrl_pkg.sv
// Shared rv32i constants for the register-file controller: register count and
// controller state encodings.
package rv32i_regfile_ctrl_pkg;
  localparam int NUM_REGS = 32;
  localparam int REG_AW   = 5;

  typedef enum logic [2:0] {
    ST_INIT    = 3'd0,
    ST_IDLE    = 3'd1,
    ST_DBG_WR  = 3'd2,
    ST_DBG_RD  = 3'd3,
    ST_DBG_RSP = 3'd4
  } state_e;
endpackage

// File: rtl/rv32i_regfile_ctrl.sv
// Register-file front end: clears x1..x31 after reset, then arbitrates between
// core traffic and a debug port, forcing a debug grant after DBG_MAX_WAIT blocked cycles.
module rv32i_regfile_ctrl #(
  parameter int DBG_MAX_WAIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  core_rs1_addr,
  input  logic [4:0]  core_rs2_addr,
  input  logic [4:0]  core_rd_addr,
  input  logic [31:0] core_rd,
  input  logic        core_wr,
  output logic        core_stall,
  input  logic        dbg_req,
  input  logic        dbg_we,
  input  logic [4:0]  dbg_addr,
  input  logic [31:0] dbg_wdata,
  output logic        dbg_ack,
  output logic [31:0] dbg_rdata,
  output logic [4:0]  rf_rs1_addr,
  output logic [4:0]  rf_rs2_addr,
  output logic [4:0]  rf_rd_addr,
  output logic [31:0] rf_rd,
  output logic        rf_wr,
  input  logic [31:0] rf_rs1
);
  import rv32i_regfile_ctrl_pkg::*;

  localparam int WW = (DBG_MAX_WAIT < 1) ? 1 : $clog2(DBG_MAX_WAIT + 1);
  localparam logic [WW-1:0] MAX_WAIT = WW'(DBG_MAX_WAIT);

  state_e              state_q, state_d;
  logic [REG_AW-1:0]   init_cnt_q, init_cnt_d;
  logic [WW-1:0]       wait_q, wait_d;
  logic [31:0]         rdata_q, rdata_d;
  logic                gap_q, gap_d;
  logic [31:0]         rd_val;

  // x0 reads as zero even if the base file does not hardwire it.
  assign rd_val = (dbg_addr == '0) ? 32'd0 : rf_rs1;

  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    wait_d     = wait_q;
    rdata_d    = rdata_q;
    gap_d      = 1'b0;
    unique case (state_q)
      ST_INIT: begin
        init_cnt_d = init_cnt_q + 1'b1;
        if (init_cnt_q == REG_AW'(NUM_REGS - 1)) state_d = ST_IDLE;
      end
      ST_IDLE: begin
        // gap_q gives the core one free IDLE cycle after every debug ack
        if (!dbg_req || gap_q) begin
          wait_d = '0;
        end else if (!core_wr || wait_q >= MAX_WAIT) begin
          wait_d  = '0;
          state_d = dbg_we ? ST_DBG_WR : ST_DBG_RD;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      ST_DBG_WR: begin
        state_d = ST_IDLE;
        gap_d   = 1'b1;
      end
      ST_DBG_RD: state_d = ST_DBG_RSP;
      ST_DBG_RSP: begin
        state_d = ST_IDLE;
        gap_d   = 1'b1;
        rdata_d = rd_val;
      end
      default: state_d = ST_INIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_INIT;
      init_cnt_q <= REG_AW'(1);
      wait_q     <= '0;
      rdata_q    <= '0;
      gap_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      init_cnt_q <= init_cnt_d;
      wait_q     <= wait_d;
      rdata_q    <= rdata_d;
      gap_q      <= gap_d;
    end
  end

  assign core_stall = rst || (state_q != ST_IDLE);
  assign dbg_ack    = !rst && ((state_q == ST_DBG_WR) || (state_q == ST_DBG_RSP));
  assign dbg_rdata  = (!rst && state_q == ST_DBG_RSP) ? rd_val : rdata_q;

  always_comb begin
    rf_rs1_addr = core_rs1_addr;
    rf_rs2_addr = core_rs2_addr;
    rf_rd_addr  = core_rd_addr;
    rf_rd       = core_rd;
    rf_wr       = 1'b0;
    unique case (state_q)
      ST_INIT: begin
        rf_rd_addr = init_cnt_q;
        rf_rd      = 32'd0;
        rf_wr      = !rst;
      end
      ST_IDLE:   rf_wr = core_wr && !rst;
      ST_DBG_WR: begin
        rf_rd_addr = dbg_addr;
        rf_rd      = dbg_wdata;
        rf_wr      = !rst;
      end
      ST_DBG_RD: rf_rs1_addr = dbg_addr;
      default: ;
    endcase
  end
endmodule

// File: tb/tb_rv32i_regfile_ctrl.sv
// Scoreboarded bench: debug transactions push expected results, a negedge
// monitor pops them on dbg_ack; a shadow register array is the reference.
module tb_rv32i_regfile_ctrl;
  localparam int MAXW = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  core_rs1_addr, core_rs2_addr, core_rd_addr;
  logic [31:0] core_rd;
  logic        core_wr, core_stall;
  logic        dbg_req, dbg_we, dbg_ack;
  logic [4:0]  dbg_addr;
  logic [31:0] dbg_wdata, dbg_rdata;
  logic [4:0]  rf_rs1_addr, rf_rs2_addr, rf_rd_addr;
  logic [31:0] rf_rd, rf_rs1;
  logic        rf_wr;

  always #5 clk = ~clk;

  rv32i_regfile_ctrl #(.DBG_MAX_WAIT(MAXW)) dut (
    .clk(clk), .rst(rst),
    .core_rs1_addr(core_rs1_addr), .core_rs2_addr(core_rs2_addr),
    .core_rd_addr(core_rd_addr), .core_rd(core_rd), .core_wr(core_wr),
    .core_stall(core_stall),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr),
    .dbg_wdata(dbg_wdata), .dbg_ack(dbg_ack), .dbg_rdata(dbg_rdata),
    .rf_rs1_addr(rf_rs1_addr), .rf_rs2_addr(rf_rs2_addr),
    .rf_rd_addr(rf_rd_addr), .rf_rd(rf_rd), .rf_wr(rf_wr), .rf_rs1(rf_rs1)
  );

  // base register file: synchronous write, one-cycle synchronous read, x0 = 0
  logic [31:0] rf_mem [32];
  always @(posedge clk) begin
    if (rf_wr && rf_rd_addr != 5'd0) rf_mem[rf_rd_addr] <= rf_rd;
    rf_rs1 <= (rf_rs1_addr == 5'd0) ? 32'd0 : rf_mem[rf_rs1_addr];
  end

  typedef struct {
    bit          is_rd;
    logic [4:0]  addr;
    logic [31:0] data;
  } exp_t;

  exp_t        sb_q[$];
  logic [31:0] ref_regs [32];
  logic [31:0] last_rd;
  int          n_tests = 0;
  int          n_fail  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    exp_t e;
    if (dbg_ack) begin
      if (rst) chk("ack_in_reset", 32'(dbg_ack), 32'd0);
      else if (sb_q.size() == 0) chk("unexpected_ack", 32'(dbg_ack), 32'd0);
      else begin
        e = sb_q.pop_front();
        if (e.is_rd) chk("rd_data", dbg_rdata, e.data);
        else begin
          chk("wr_rf_wr", 32'(rf_wr), 32'd1);
          chk("wr_rf_addr", 32'(rf_rd_addr), 32'(e.addr));
          chk("wr_rf_data", rf_rd, e.data);
        end
      end
    end
  end

  task automatic clear_model();
    for (int i = 0; i < 32; i++) ref_regs[i] = 32'd0;
  endtask

  task automatic push_exp(input bit we, input logic [4:0] a, input logic [31:0] d);
    exp_t e;
    e.is_rd = !we;
    e.addr  = a;
    e.data  = we ? d : ref_regs[a];
    sb_q.push_back(e);
    if (we && a != 5'd0) ref_regs[a] = d;
    if (!we) last_rd = ref_regs[a];
  endtask

  // waits (bounded) for dbg_ack, then drops the request and lets the gap cycle pass
  task automatic wait_ack(output int lat);
    bit got = 1'b0;
    lat = 0;
    while (!got && lat < 40) begin
      @(posedge clk); lat++;
      @(negedge clk); got = dbg_ack;
    end
    if (!got) chk("ack_timeout", 32'(dbg_ack), 32'd1);
    @(posedge clk); #1 dbg_req = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic dbg_txn(input bit we, input logic [4:0] a, input logic [31:0] d);
    int lat;
    push_exp(we, a, d);
    dbg_req = 1'b1; dbg_we = we; dbg_addr = a; dbg_wdata = d;
    wait_ack(lat);
    if (we) chk("wr_latency", 32'(lat), 32'd1);
    else    chk("rd_latency", 32'(lat), 32'd2);
  endtask

  // called just after reset is released
  task automatic check_init(input bit with_req);
    int lat;
    if (with_req) begin
      push_exp(1'b0, 5'd7, 32'd0);
      dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 5'd7;
    end
    for (int i = 1; i <= 31; i++) begin
      @(negedge clk);
      chk("init_wr", 32'(rf_wr), 32'd1);
      chk("init_addr", 32'(rf_rd_addr), 32'(i));
      chk("init_data", rf_rd, 32'd0);
      chk("init_stall", 32'(core_stall), 32'd1);
      chk("init_no_ack", 32'(dbg_ack), 32'd0);
      @(posedge clk);
    end
    @(negedge clk);
    chk("init_done_stall", 32'(core_stall), 32'd0);
    if (with_req) begin
      wait_ack(lat);
      chk("init_req_lat", 32'(lat), 32'd2);
    end else begin
      @(posedge clk); #1;
    end
  endtask

  task automatic core_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      core_wr       = 1'($urandom_range(0, 1));
      core_rd_addr  = 5'($urandom);
      core_rd       = $urandom;
      core_rs1_addr = 5'($urandom);
      core_rs2_addr = 5'($urandom);
      @(negedge clk);
      chk("pt_wr", 32'(rf_wr), 32'(core_wr));
      chk("pt_rd_addr", 32'(rf_rd_addr), 32'(core_rd_addr));
      chk("pt_rd", rf_rd, core_rd);
      chk("pt_rs1", 32'(rf_rs1_addr), 32'(core_rs1_addr));
      chk("pt_rs2", 32'(rf_rs2_addr), 32'(core_rs2_addr));
      chk("pt_stall", 32'(core_stall), 32'd0);
      if (core_wr && core_rd_addr != 5'd0) ref_regs[core_rd_addr] = core_rd;
      @(posedge clk); #1;
    end
    core_wr = 1'b0;
  endtask

  initial begin
    logic [31:0] blk_d;
    bit          stall_exp;
    rst = 1'b1; core_wr = 1'b0; core_rd = '0; core_rd_addr = '0;
    core_rs1_addr = '0; core_rs2_addr = '0;
    dbg_req = 1'b0; dbg_we = 1'b0; dbg_addr = '0; dbg_wdata = '0;
    last_rd = '0;
    clear_model();

    repeat (3) begin
      @(negedge clk);
      chk("rst_stall", 32'(core_stall), 32'd1);
      chk("rst_rf_wr", 32'(rf_wr), 32'd0);
      chk("rst_ack", 32'(dbg_ack), 32'd0);
    end
    chk("rst_rdata", dbg_rdata, 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    check_init(1'b1);

    // directed write/read, x0 handling, read-data hold
    dbg_txn(1'b1, 5'd5, 32'hDEADBEEF);
    dbg_txn(1'b0, 5'd5, 32'd0);
    dbg_txn(1'b1, 5'd0, 32'h0000_1234);
    dbg_txn(1'b0, 5'd0, 32'd0);
    dbg_txn(1'b0, 5'd5, 32'd0);
    dbg_txn(1'b1, 5'd6, 32'h1111_2222);
    chk("rdata_hold", dbg_rdata, last_rd);

    core_cycles(6);

    // debug read blocked by a 10-cycle core write burst
    blk_d = $urandom;
    core_wr = 1'b1; core_rd_addr = 5'd10; core_rd = blk_d;
    core_rs1_addr = 5'd1; core_rs2_addr = 5'd2;
    push_exp(1'b0, 5'd5, 32'd0);
    ref_regs[10] = blk_d;
    dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 5'd5;
    for (int j = 0; j < 12; j++) begin
      stall_exp = (j == MAXW + 1) || (j == MAXW + 2);
      @(negedge clk);
      chk("blk_stall", 32'(core_stall), 32'(stall_exp));
      chk("blk_ack", 32'(dbg_ack), 32'(j == MAXW + 2));
      chk("blk_rf_wr", 32'(rf_wr), 32'((j < 10) && !stall_exp));
      if (j == MAXW + 3) begin
        chk("blk_land_addr", 32'(rf_rd_addr), 32'd10);
        chk("blk_land_data", rf_rd, blk_d);
      end
      @(posedge clk); #1;
      if (j == MAXW + 2) dbg_req = 1'b0;
      if (j == 9) core_wr = 1'b0;
    end
    dbg_txn(1'b0, 5'd10, 32'd0);

    // randomized traffic
    for (int k = 0; k < 30; k++) begin
      dbg_txn(1'($urandom_range(0, 1)), 5'($urandom), $urandom);
      core_cycles($urandom_range(0, 3));
    end

    // reset while in DBG_RD: no ack, rdata cleared, init restarts
    dbg_txn(1'b1, 5'd3, 32'hA5A5_0001);
    dbg_txn(1'b0, 5'd3, 32'd0);
    dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 5'd3;
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    chk("rstrd_ack", 32'(dbg_ack), 32'd0);
    chk("rstrd_stall", 32'(core_stall), 32'd1);
    chk("rstrd_rf_wr", 32'(rf_wr), 32'd0);
    @(posedge clk); #1 dbg_req = 1'b0;
    @(negedge clk);
    chk("rstrd_rdata", dbg_rdata, 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    clear_model();
    check_init(1'b0);
    dbg_txn(1'b0, 5'd3, 32'd0);

    chk("sb_drain", 32'(sb_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
endmodule

// File: doc/rv32i_regfile_ctrl.md
RV32I_REGFILE_CTRL -- requirements
Module: rv32i_regfile_ctrl

Interface
REQ-001 SHALL have parameter DBG_MAX_WAIT, default 4, meaning cycles a debug request may be blocked by core writes before forced grant.
REQ-002 SHALL have ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous reset, active-high
- core_rs1_addr  in  5  core read address 1
- core_rs2_addr  in  5  core read address 2
- core_rd_addr  in  5  core write address
- core_rd  in  32  core write data
- core_wr  in  1  core write enable
- core_stall  out  1  controller owns register file; core holds all inputs
- dbg_req  in  1  debug access request, held until dbg_ack
- dbg_we  in  1  1 = write, 0 = read
- dbg_addr  in  5  debug register address
- dbg_wdata  in  32  debug write data
- dbg_ack  out  1  one-cycle completion pulse
- dbg_rdata  out  32  debug read data, valid with dbg_ack
- rf_rs1_addr, rf_rs2_addr, rf_rd_addr  out  5  to base register file
- rf_rd  out  32  write data to base register file
- rf_wr  out  1  write enable to base register file
- rf_rs1  in  32  read data 1 from base register file (1-cycle synchronous read)
REQ-003 SHALL have one clock (clk); reset (rst) is synchronous and active-high.

Function
REQ-004 SHALL implement states INIT, IDLE, DBG_WR, DBG_RD, DBG_RSP.
REQ-005 INIT: write 0 to addresses 1..31 in ascending order, one per cycle (31 cycles); core_stall=1; go to IDLE after address 31 is written.
REQ-006 INIT SHALL ignore dbg_req (no dbg_ack).
REQ-007 IDLE: rf_rs1_addr/rf_rs2_addr/rf_rd_addr/rf_rd/rf_wr pass through the core_* inputs combinationally; core_stall=0.
REQ-008 IDLE, dbg_req=1 and core_wr=0: grant; go to DBG_WR if dbg_we=1, else DBG_RD.
REQ-009 IDLE, dbg_req=1 and core_wr=1: core write proceeds; wait counter increments; when it reaches DBG_MAX_WAIT, grant regardless of core_wr (core_stall=1 from next cycle; core holds its write).
REQ-010 Wait counter SHALL clear on every grant and whenever dbg_req=0.
REQ-011 DBG_WR: rf_rd_addr=dbg_addr, rf_rd=dbg_wdata, rf_wr=1, dbg_ack=1, core_stall=1; next state IDLE.
REQ-012 DBG_RD: rf_rs1_addr=dbg_addr, rf_wr=0, core_stall=1; next state DBG_RSP.
REQ-013 DBG_RSP: dbg_rdata latched from rf_rs1; dbg_ack=1; core_stall=1; rf_rs1_addr/rf_rs2_addr driven from core_* so the core's re-read is valid; rf_wr=0; next state IDLE.
REQ-014 dbg_rdata SHALL hold its value until the next debug read completes.
REQ-015 core_wr SHALL be ignored whenever core_stall=1; rf_wr is never driven by the core in DBG_* or INIT states.
REQ-016 Debug write or read to address 0 SHALL complete normally (ack in same latency); a read returns 0.
REQ-017 Debug read latency: dbg_ack two cycles after grant; debug write latency: dbg_ack one cycle after grant.
REQ-018 After dbg_ack, a new grant SHALL NOT occur until at least one IDLE cycle with core_stall=0.

Reset
REQ-019 rst=1 in any state SHALL force next state INIT with counter=1, wait counter=0, dbg_rdata=0, dbg_ack=0.
REQ-020 While rst=1: rf_wr=0, core_stall=1, dbg_ack=0.
REQ-021 A debug transaction interrupted by reset SHALL NOT be acked; the requester re-issues.

Structure
REQ-022 State encodings and register count (32) SHALL live in the shared rv32i header of constants.
REQ-023 Single flat module, no sub-modules; instantiated beside the base register file in the core top.

Verification
REQ-024 Reset release -> 31 cycles rf_wr=1, rf_rd=0, rf_rd_addr 1..31; core_stall falls on cycle 32.
REQ-025 IDLE, dbg write addr 5 data 0xDEADBEEF, core_wr=0 -> next cycle rf_wr=1 addr 5, dbg_ack=1; later debug read addr 5 -> dbg_rdata=0xDEADBEEF two cycles after grant.
REQ-026 dbg_req read with core_wr=1 for 10 cycles, DBG_MAX_WAIT=4 -> grant after 4 blocked cycles; core_stall=1 for 2 cycles; core write lands after stall drops.
REQ-027 Debug read addr 0 -> dbg_ack with dbg_rdata=0.
REQ-028 rst asserted in DBG_RD -> no dbg_ack, INIT restarts at address 1, dbg_rdata=0.
